// File: rtl/packet_writer_pkg.sv
// packet_writer_pkg: packet layout constants shared by the TX writer and the RX reader.
// Rev 1.0 - initial release.
`default_nettype none

package packet_writer_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT   = 8'hA5;
  localparam int         OPCODE_BYTE_DEFAULT = 2;
  localparam int         SYNC_IDX            = 0;
  localparam int         LEN_BYTE            = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_PUSH = 2'd2;

  // Payload lives between the opcode and the trailing checksum byte.
  function automatic int payload_max(input int size, input int opcode_byte);
    return size - opcode_byte - 2;
  endfunction

  function automatic int csum_byte(input int size);
    return size - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/packet_writer.sv
// packet_writer: builds one fixed-size response packet from streamed payload bytes
// and writes it to the TX FIFO as a single wide word. Rev 1.0 - initial release.
`default_nettype none

module packet_writer
  import packet_writer_pkg::*;
#(
  parameter int         SIZE        = 256,
  parameter int         OPCODE_BYTE = OPCODE_BYTE_DEFAULT,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        opcode,
  input  logic [7:0]        len,
  output logic              busy,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [8*SIZE-1:0] wr_data,
  output logic              done
);

  localparam int         PAYLOAD_MAX   = payload_max(SIZE, OPCODE_BYTE);
  localparam logic [7:0] PAYLOAD_MAX_B = 8'(PAYLOAD_MAX);
  localparam int         CSUM_IDX      = csum_byte(SIZE);
  localparam int         IDX_W         = $clog2(8 * SIZE);

  logic [1:0]        state_q, state_d;
  logic [8*SIZE-1:0] buf_q, buf_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        len_c;
  logic [IDX_W-1:0]  pay_lo;

  assign len_c  = (len > PAYLOAD_MAX_B) ? PAYLOAD_MAX_B : len;
  assign pay_lo = IDX_W'((OPCODE_BYTE + 1 + int'(cnt_q)) * 8);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    csum_d  = csum_q;
    wr_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          buf_d                         = '0;
          buf_d[8*SYNC_IDX +: 8]        = SYNC_BYTE;
          buf_d[8*LEN_BYTE +: 8]        = len_c;
          buf_d[8*OPCODE_BYTE +: 8]     = opcode;
          csum_d                        = SYNC_BYTE ^ len_c ^ opcode;
          cnt_d                         = 8'd0;
          len_d                         = len_c;
          if (len_c == 8'd0) begin
            buf_d[8*CSUM_IDX +: 8] = csum_d;
            state_d                = ST_PUSH;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (byte_valid) begin
          buf_d[pay_lo +: 8] = byte_data;
          csum_d             = csum_q ^ byte_data;
          cnt_d              = cnt_q + 8'd1;
          // Checksum lands in the word on PUSH entry so wr_data is final there.
          if (cnt_d == len_q) begin
            buf_d[8*CSUM_IDX +: 8] = csum_d;
            state_d                = ST_PUSH;
          end
        end
      end
      ST_PUSH: begin
        if (!fifo_full) begin
          wr_en_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= 8'd0;
      len_q   <= 8'd0;
      csum_q  <= 8'd0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      wr_en_q <= wr_en_d;
    end
  end

  // The write cycle still counts as busy even though the FSM is back in IDLE.
  assign busy       = (state_q != ST_IDLE) | wr_en_q;
  assign byte_ready = (state_q == ST_FILL);
  assign wr_en      = wr_en_q;
  assign done       = wr_en_q;
  assign wr_data    = buf_q;

endmodule

`default_nettype wire

// File: tb/tb_packet_writer.sv
// tb_packet_writer: randomized and directed self-checking bench for packet_writer (SIZE=8).
// Rev 1.0 - initial release.
`default_nettype none

module tb_packet_writer;

  logic        CLK;
  logic        rst;
  logic        start;
  logic [7:0]  opcode;
  logic [7:0]  len;
  logic        busy;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        fifo_full;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        done;

  packet_writer #(.SIZE(8), .OPCODE_BYTE(2), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .rst(rst), .start(start), .opcode(opcode), .len(len), .busy(busy),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data), .done(done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  tx_bytes [0:15];
  int          tx_n;

  logic [63:0] got_data;
  int          n_writes, n_accepted, wr_cycle, last_hs, push_cycles;
  int          stable_bad, done_bad;
  logic        busy_at_wr, busy_after;
  bit          timed_out;

  // Reference: lay out the packet bytes and XOR every byte before the checksum slot.
  function automatic logic [63:0] model(input logic [7:0] op, input logic [7:0] ln);
    logic [7:0]  b [0:7];
    logic [63:0] w;
    int          lc;
    lc = (ln > 8'd4) ? 4 : int'(ln);
    for (int i = 0; i < 8; i++) b[i] = 8'h00;
    b[0] = 8'hA5;
    b[1] = 8'(lc);
    b[2] = op;
    for (int i = 0; i < lc; i++) b[3 + i] = tx_bytes[i];
    b[7] = 8'h00;
    for (int i = 0; i < 7; i++) b[7] = b[7] ^ b[i];
    for (int i = 0; i < 8; i++) w[8*i +: 8] = b[i];
    return w;
  endfunction

  task automatic send_packet(input logic [7:0] op, input logic [7:0] ln, input int gap_pct,
                             input int full_cycles, input bit extra_starts);
    int   idx;
    int   post;
    bit   seen;
    bit   push_started;
    bit   in_push;
    logic [63:0] push_data;
    n_writes = 0; n_accepted = 0; wr_cycle = -1; last_hs = -1; push_cycles = 0;
    stable_bad = 0; done_bad = 0; busy_at_wr = 1'b0; busy_after = 1'b1; timed_out = 1'b0;
    idx = 0; post = 0; seen = 1'b0; push_started = 1'b0; push_data = '0;
    @(negedge CLK);
    start = 1'b1; opcode = op; len = ln; byte_valid = 1'b0; fifo_full = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      if (done !== wr_en) done_bad++;
      if (seen) begin
        post++;
        if (post == 1) busy_after = busy;
      end
      if (wr_en === 1'b1) begin
        n_writes++;
        if (!seen) begin
          seen       = 1'b1;
          got_data   = wr_data;
          wr_cycle   = cyc;
          busy_at_wr = busy;
          if (push_started && wr_data !== push_data) stable_bad++;
        end
      end
      if (post >= 4) break;
      in_push = busy && !byte_ready && !wr_en;
      if (in_push) begin
        if (!push_started) begin
          push_started = 1'b1;
          push_data    = wr_data;
        end else if (wr_data !== push_data) begin
          stable_bad++;
        end
        push_cycles++;
      end
      fifo_full  = in_push && (push_cycles <= full_cycles);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      if (!seen && idx < tx_n && $urandom_range(99) >= gap_pct) begin
        byte_valid = 1'b1;
        byte_data  = tx_bytes[idx];
        if (byte_ready) begin
          idx++;
          last_hs = cyc;
        end
      end
      if (extra_starts && busy && !wr_en && $urandom_range(2) == 0) begin
        start  = 1'b1;
        opcode = 8'($urandom);
        len    = 8'($urandom);
      end
    end
    start = 1'b0; byte_valid = 1'b0; fifo_full = 1'b0;
    if (!seen) timed_out = 1'b1;
    n_accepted = idx;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = '0; len = '0; byte_valid = 1'b0; byte_data = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) $display("FAIL reset_busy_ready: busy=%b ready=%b, need 0/0", busy, byte_ready);
    else n_pass++;
    n_checks++;
    if (wr_en !== 1'b0 || done !== 1'b0) $display("FAIL reset_wr_done: wr_en=%b done=%b, need 0/0", wr_en, done);
    else n_pass++;
    n_checks++;
    if (wr_data !== 64'h0) $display("FAIL reset_wr_data: got %h, need 0", wr_data);
    else n_pass++;
    rst = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || wr_data !== 64'h0)
      $display("FAIL reset_release: busy=%b wr_en=%b data=%h, need idle", busy, wr_en, wr_data);
    else n_pass++;
  endtask

  task automatic test_basic();
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h02; tx_n = 2;
    send_packet(8'h10, 8'd2, 0, 0, 1'b0);
    n_checks++;
    if (timed_out || got_data !== 64'hB400000201_1002A5) $display("FAIL basic_data: got %h, need B4000002011002A5", got_data);
    else n_pass++;
    n_checks++;
    if (n_writes !== 1 || done_bad !== 0) $display("FAIL basic_writes: writes=%0d done_bad=%0d, need 1/0", n_writes, done_bad);
    else n_pass++;
    n_checks++;
    if (busy_at_wr !== 1'b1 || busy_after !== 1'b0) $display("FAIL basic_busy: at_wr=%b after=%b, need 1/0", busy_at_wr, busy_after);
    else n_pass++;
    n_checks++;
    if (wr_cycle !== last_hs + 2) $display("FAIL basic_latency: wr at %0d, last byte %0d, need +2", wr_cycle, last_hs);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    tx_n = 0;
    send_packet(8'h7F, 8'd0, 0, 0, 1'b0);
    n_checks++;
    if (timed_out || got_data !== 64'hDA000000007F00A5) $display("FAIL zero_len_data: got %h, need DA000000007F00A5", got_data);
    else n_pass++;
    n_checks++;
    if (wr_cycle !== 2) $display("FAIL zero_len_latency: wr_en at cycle %0d, need 2", wr_cycle);
    else n_pass++;
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 9; i++) tx_bytes[i] = 8'($urandom);
    tx_n = 9;
    send_packet(8'h10, 8'd9, 0, 0, 1'b0);
    n_checks++;
    if (n_accepted !== 4) $display("FAIL clamp_accepted: got %0d bytes, need 4", n_accepted);
    else n_pass++;
    n_checks++;
    if (got_data[15:8] !== 8'h04) $display("FAIL clamp_len_byte: got %h, need 04", got_data[15:8]);
    else n_pass++;
    n_checks++;
    if (timed_out || got_data !== model(8'h10, 8'd9)) $display("FAIL clamp_data: got %h, need %h", got_data, model(8'h10, 8'd9));
    else n_pass++;
  endtask

  task automatic test_fifo_full();
    tx_bytes[0] = 8'hC3; tx_bytes[1] = 8'h3C; tx_bytes[2] = 8'h99; tx_n = 3;
    send_packet(8'h42, 8'd3, 0, 5, 1'b0);
    n_checks++;
    if (n_writes !== 1 || stable_bad !== 0) $display("FAIL full_writes: writes=%0d unstable=%0d, need 1/0", n_writes, stable_bad);
    else n_pass++;
    n_checks++;
    if (push_cycles !== 6) $display("FAIL full_hold: push cycles=%0d, need 6", push_cycles);
    else n_pass++;
    n_checks++;
    if (timed_out || got_data !== model(8'h42, 8'd3)) $display("FAIL full_data: got %h, need %h", got_data, model(8'h42, 8'd3));
    else n_pass++;
  endtask

  task automatic test_gaps_busy_starts();
    for (int i = 0; i < 4; i++) tx_bytes[i] = 8'(8'h11 * (i + 1));
    tx_n = 4;
    send_packet(8'h5A, 8'd4, 60, 2, 1'b1);
    n_checks++;
    if (timed_out || got_data !== model(8'h5A, 8'd4)) $display("FAIL gaps_data: got %h, need %h", got_data, model(8'h5A, 8'd4));
    else n_pass++;
    n_checks++;
    if (n_writes !== 1 || busy_after !== 1'b0) $display("FAIL gaps_writes: writes=%0d busy_after=%b, need 1/0", n_writes, busy_after);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int wr_seen;
    wr_seen = 0;
    @(negedge CLK);
    start = 1'b1; opcode = 8'h33; len = 8'd3;
    @(negedge CLK);
    start = 1'b0; byte_valid = 1'b1; byte_data = 8'h55;
    @(negedge CLK);
    byte_valid = 1'b1; byte_data = 8'h66;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0 || wr_data !== 64'h0)
      $display("FAIL async_reset_outputs: busy=%b ready=%b wr=%b done=%b data=%h, need all 0",
               busy, byte_ready, wr_en, done, wr_data);
    else n_pass++;
    byte_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (wr_en !== 1'b0) wr_seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (wr_en !== 1'b0 || busy !== 1'b0) wr_seen++;
    end
    n_checks++;
    if (wr_seen !== 0) $display("FAIL async_reset_no_write: bad cycles=%0d, need 0", wr_seen);
    else n_pass++;
    tx_n = 0;
    send_packet(8'h7F, 8'd0, 0, 0, 1'b0);
    n_checks++;
    if (timed_out || got_data !== 64'hDA000000007F00A5) $display("FAIL async_reset_next: got %h, need DA000000007F00A5", got_data);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] op;
    logic [7:0] ln;
    int         lc;
    for (int t = 0; t < 10; t++) begin
      op = 8'($urandom);
      ln = 8'($urandom_range(0, 7));
      lc = (ln > 8'd4) ? 4 : int'(ln);
      for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom);
      tx_n = int'(ln);
      send_packet(op, ln, $urandom_range(0, 50), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      n_checks++;
      if (timed_out || got_data !== model(op, ln))
        $display("FAIL random_data[%0d]: op=%h len=%0d got %h, need %h", t, op, ln, got_data, model(op, ln));
      else n_pass++;
      n_checks++;
      if (n_writes !== 1 || n_accepted !== lc || done_bad !== 0 || stable_bad !== 0)
        $display("FAIL random_proto[%0d]: writes=%0d acc=%0d done_bad=%0d unstable=%0d, need 1/%0d/0/0",
                 t, n_writes, n_accepted, done_bad, stable_bad, lc);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_clamp();
    test_fifo_full();
    test_gaps_busy_starts();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
